multibyte_adder_seq: RTL and testbench
======================================

# multibyte_adder_seq

Sequential multi-byte adder that drives the team's 8-bit combinational `adder` one byte per clock, from LSB to MSB. It chains carry-out into the next byte's carry-in through a register. It accepts wide operands on a start/done handshake and produces a registered wide sum with carry, signed-overflow and zero flags. It sits directly upstream of the 8-bit adder, feeding its `a`, `b` and `cin` inputs, and consumes its `sum`, `C`, `V` and `Z` outputs.

## Interface
- `NBYTES`, default 4: operand width in bytes; legal range 2..16.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `start`  in  1: request; sampled only in IDLE.
- `op_a`  in  8*NBYTES: operand A.
- `op_b`  in  8*NBYTES: operand B.
- `cin`  in  1: carry into byte 0.
- `busy`  out  1: high in RUN and DONE.
- `done`  out  1: one-cycle pulse; results are valid from this cycle.
- `result`  out  8*NBYTES: registered sum, modulo 2^(8*NBYTES).
- `carry_out`  out  1: carry out of the MSB byte.
- `overflow`  out  1: two's-complement overflow of the full-width add, equal to `V` of the MSB byte.
- `zero`  out  1: result == 0, equal to the AND of every byte's `Z`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when `start` = 1.
  - RUN -> DONE after byte NBYTES-1 is processed.
  - DONE -> IDLE unconditionally.
- Start acceptance, at the IDLE edge where `start` = 1:
  - latch `op_a`, `op_b` and `cin`;
  - clear `result`, `carry_out`, `overflow`, `zero`;
  - set byte index `idx` = 0, carry register = `cin`, zero accumulator = 1.
- Each RUN cycle:
  - present byte `idx` of the latched A and B to `adder`, with `cin` = carry register;
  - at the edge, write `sum` into `result[8*idx +: 8]`;
  - carry register <= `C`;
  - zero accumulator <= zero accumulator & `Z`;
  - `idx` increments.
- On the last byte, `carry_out` <= `C`, `overflow` <= `V`, `zero` <= zero accumulator & `Z`.
- `start` is ignored in RUN and DONE. It is not queued. Holding it high causes a new accept on the cycle after the return to IDLE.
- Input changes after acceptance have no effect.
- `result` and the flags hold their values after DONE until the next accept.
- Reset, including mid-operation:
  - state = IDLE, `idx` = 0;
  - all outputs 0 (`busy`, `done`, `result`, `carry_out`, `overflow`, `zero`);
  - any in-flight operation is discarded.

## Timing
- Accept edge = edge 0. Byte k is written at edge k+1.
- `done` = 1 and `busy` = 1 during the cycle following edge NBYTES.
- IDLE is re-entered at edge NBYTES+1.
- Latency from accept to `done` is NBYTES+1 cycles. The minimum issue interval is NBYTES+2 cycles.
- `busy` rises in the cycle after the accept edge.
- `result` bytes update progressively during RUN. Bytes are only valid once `done` has been seen.
- The adder path is combinational within one cycle. No other combinational path exists from inputs to outputs; all outputs are registered.

## Configuration
- Macro: `MULTIBYTE_ADDER_SUBTRACT_EN`.
- With the macro defined:
  - an extra input port `sub` (1 bit) is sampled at accept;
  - when `sub` = 1, each B byte is inverted before the adder and the initial carry is forced to 1, so `cin` is ignored;
  - the result is A - B;
  - `carry_out` = 1 means no borrow;
  - `overflow` and `zero` follow the same rules as for addition.
- Without the macro, there is no `sub` port and the block performs addition only.

## Structure
- Package `multibyte_adder_pkg`:
  - state enum (IDLE, RUN, DONE);
  - `BYTE_W` = 8;
  - function `idx_w(NBYTES)` for the index counter width.
- Sub-module: one instance of the 8-bit combinational `adder`, with ports `a`, `b`, `cin`, `sum`, `C`, `V`, `Z`. The block contains no other arithmetic.

## Test plan
All scenarios use NBYTES = 4.
- 0x000000FF + 0x00000001, `cin` = 0 -> `result` = 0x00000100, C = 0, V = 0, Z = 0; `done` is high in the cycle after edge 4, for exactly one cycle.
- 0xFFFFFFFF + 0x00000000, `cin` = 1 -> `result` = 0x00000000, `carry_out` = 1, `overflow` = 0, `zero` = 1.
- 0x7FFFFFFF + 0x00000001 -> 0x80000000, `overflow` = 1, `carry_out` = 0; and 0x80000000 + 0x80000000 -> 0x00000000, C = 1, V = 1, Z = 1.
- `start` held high with operands changed during RUN -> only the first operands are summed. `done` pulses once. The next accept occurs at edge 6, and `done` pulses again after a further 5 cycles.
- `rst_n` pulsed low after edge 2 of RUN -> all outputs are 0 immediately and the FSM is in IDLE. A following 0x00000003 + 0x00000004 completes normally with 0x00000007.
- With `MULTIBYTE_ADDER_SUBTRACT_EN`: 5 - 7 with `sub` = 1 -> 0xFFFFFFFE, `carry_out` = 0, `overflow` = 0, `zero` = 0; 7 - 7 -> 0, `carry_out` = 1, `zero` = 1.

Source files
------------

// File: rtl/multibyte_adder_pkg.sv
// Shared types and constants for the byte-serial multi-byte adder.
// The optional subtract mode is selected with MULTIBYTE_ADDER_SUBTRACT_EN.
package multibyte_adder_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Byte-index counter width; at least one bit even for the 2-byte case.
    function automatic int idx_w(input int nbytes);
        return (nbytes <= 2) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/multibyte_adder_seq_adder.sv
// 8-bit combinational adder with carry, signed-overflow and zero flags.
module adder
    import multibyte_adder_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              C,
    output logic              V,
    output logic              Z
);

    logic [BYTE_W:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};
        sum  = full[BYTE_W-1:0];
        C    = full[BYTE_W];
        V    = (a[BYTE_W-1] == b[BYTE_W-1]) && (full[BYTE_W-1] != a[BYTE_W-1]);
        Z    = (full[BYTE_W-1:0] == '0);
    end

endmodule

// File: rtl/multibyte_adder_seq.sv
// Byte-serial wide adder: one 8-bit adder slice per clock, LSB first, start/done handshake.
// Define MULTIBYTE_ADDER_SUBTRACT_EN to add the `sub` port (A - B mode).
module multibyte_adder_seq
    import multibyte_adder_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [BYTE_W*NBYTES-1:0] op_a,
    input  logic [BYTE_W*NBYTES-1:0] op_b,
    input  logic                     cin,
`ifdef MULTIBYTE_ADDER_SUBTRACT_EN
    input  logic                     sub,
`endif
    output logic                     busy,
    output logic                     done,
    output logic [BYTE_W*NBYTES-1:0] result,
    output logic                     carry_out,
    output logic                     overflow,
    output logic                     zero
);

    localparam int W  = BYTE_W * NBYTES;
    localparam int IW = idx_w(NBYTES);

    typedef logic [IW-1:0] idx_t;

    localparam idx_t LAST = idx_t'(NBYTES - 1);

    state_e         state_q, state_d;
    idx_t           idx_q, idx_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           carry_q, carry_d;
    logic           zacc_q, zacc_d;
    logic [W-1:0]   result_q, result_d;
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;
    logic           zero_q, zero_d;

    logic [BYTE_W-1:0] add_a, add_b, add_sum;
    logic              add_c, add_v, add_z;

    assign add_a = a_q[BYTE_W*idx_q +: BYTE_W];
    assign add_b = b_q[BYTE_W*idx_q +: BYTE_W];

    adder u_adder (
        .a   (add_a),
        .b   (add_b),
        .cin (carry_q),
        .sum (add_sum),
        .C   (add_c),
        .V   (add_v),
        .Z   (add_z)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        zacc_d   = zacc_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    a_d      = op_a;
                    idx_d    = '0;
                    zacc_d   = 1'b1;
                    result_d = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    zero_d   = 1'b0;
`ifdef MULTIBYTE_ADDER_SUBTRACT_EN
                    // B is stored pre-inverted so RUN needs no knowledge of the mode.
                    b_d      = sub ? ~op_b : op_b;
                    carry_d  = sub ? 1'b1 : cin;
`else
                    b_d      = op_b;
                    carry_d  = cin;
`endif
                end
            end
            RUN: begin
                result_d[BYTE_W*idx_q +: BYTE_W] = add_sum;
                carry_d = add_c;
                zacc_d  = zacc_q & add_z;
                if (idx_q == LAST) begin
                    state_d = DONE;
                    idx_d   = '0;
                    cout_d  = add_c;
                    ovf_d   = add_v;
                    zero_d  = zacc_q & add_z;
                end else begin
                    idx_d = idx_q + idx_t'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            zacc_q   <= zacc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_multibyte_adder_seq.sv
// Directed + random bench for multibyte_adder_seq (NBYTES = 4), scoreboard-checked.
module tb_multibyte_adder_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a, op_b;
    logic         cin;
`ifdef MULTIBYTE_ADDER_SUBTRACT_EN
    logic         sub;
`endif
    logic         busy, done, carry_out, overflow, zero;
    logic [W-1:0] result;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    exp_t sb[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    multibyte_adder_seq #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
`ifdef MULTIBYTE_ADDER_SUBTRACT_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Full-width reference computed directly on the wide operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        exp_t       e;
        logic [W:0] s;
        s     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        e.res = s[W-1:0];
        e.c   = s[W];
        e.v   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        e.z   = (s[W-1:0] == '0);
        return e;
    endfunction

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_result"},   result,    e.res);
            chk({tag, "_carry"},    carry_out, e.c);
            chk({tag, "_overflow"}, overflow,  e.v);
            chk({tag, "_zero"},     zero,      e.z);
        end
    endtask

    // Issue one operation and follow it through to the return to IDLE.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sb_sub, input exp_t e);
        op_a  = a;
        op_b  = b;
        cin   = ci;
`ifdef MULTIBYTE_ADDER_SUBTRACT_EN
        sub   = sb_sub;
`endif
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = ~a;
        op_b  = ~b;
        chk({tag, "_busy_rise"}, busy, 1'b1);
        for (int k = 1; k <= NB; k++) begin
            @(posedge clk);
            #1;
            chk({tag, "_done_timing"}, done, (k == NB));
            if (k == NB) check_out(tag);
        end
        @(posedge clk);
        #1;
        chk({tag, "_done_fall"}, done, 1'b0);
        chk({tag, "_idle"},      busy, 1'b0);
        chk({tag, "_hold"},      result, e.res);
    endtask

    initial begin
        exp_t e;
        logic [W-1:0] ra, rb;
        logic         rc;

        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
`ifdef MULTIBYTE_ADDER_SUBTRACT_EN
        sub   = 1'b0;
`endif
        #1;
        chk("rst_busy",   busy,      1'b0);
        chk("rst_done",   done,      1'b0);
        chk("rst_result", result,    32'h0);
        chk("rst_carry",  carry_out, 1'b0);
        chk("rst_ovf",    overflow,  1'b0);
        chk("rst_zero",   zero,      1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("ff_plus_1",  32'h000000FF, 32'h00000001, 1'b0, 1'b0, '{32'h00000100, 1'b0, 1'b0, 1'b0});
        run_op("ones_cin",   32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, '{32'h00000000, 1'b1, 1'b0, 1'b1});
        run_op("pos_ovf",    32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h80000000, 1'b0, 1'b1, 1'b0});
        run_op("neg_ovf",    32'h80000000, 32'h80000000, 1'b0, 1'b0, '{32'h00000000, 1'b1, 1'b1, 1'b1});

        // start held high; operands swapped after accept; second accept at edge 6
        op_a  = 32'h11111111;
        op_b  = 32'h22222222;
        cin   = 1'b0;
        start = 1'b1;
        sb.push_back('{32'h33333333, 1'b0, 1'b0, 1'b0});
        sb.push_back('{32'h00000004, 1'b1, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        op_a = 32'hA0000001;
        op_b = 32'h60000002;
        cin  = 1'b1;
        for (int e2 = 1; e2 <= 11; e2++) begin
            @(posedge clk);
            #1;
            if (e2 == 6) start = 1'b0;
            chk("hold_done", done, (e2 == 4 || e2 == 10));
            chk("hold_busy", busy, !(e2 == 5 || e2 == 11));
            if (e2 == 4 || e2 == 10) check_out("hold");
        end

        // asynchronous reset two edges into RUN
        op_a  = 32'h12345678;
        op_b  = 32'h11111111;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("midrun_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy",   busy,      1'b0);
        chk("arst_done",   done,      1'b0);
        chk("arst_result", result,    32'h0);
        chk("arst_carry",  carry_out, 1'b0);
        chk("arst_ovf",    overflow,  1'b0);
        chk("arst_zero",   zero,      1'b0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("after_rst", 32'h00000003, 32'h00000004, 1'b0, 1'b0, '{32'h00000007, 1'b0, 1'b0, 1'b0});

`ifdef MULTIBYTE_ADDER_SUBTRACT_EN
        run_op("sub_5_7", 32'd5, 32'd7, 1'b0, 1'b1, '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b0});
        run_op("sub_7_7", 32'd7, 32'd7, 1'b0, 1'b1, '{32'h00000000, 1'b1, 1'b0, 1'b1});
`endif

        for (int i = 0; i < 6; i++) begin
            ra = $urandom();
            rb = $urandom();
            rc = 1'($urandom_range(0, 1));
            e  = model(ra, rb, rc);
            run_op("rand", ra, rb, rc, 1'b0, e);
        end

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
